// File: rtl/regfile_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl_if
// Writeback bus between the two writeback requesters (ALU, LSU), the
// writeback controller and the register-file write port.
//   i_alu_valid/o_alu_ready/i_alu_rd_addr/i_alu_rd_data : ALU writeback channel
//   i_lsu_valid/o_lsu_ready/i_lsu_rd_addr/i_lsu_rd_data : LSU writeback channel
//   o_rd_wren/o_rd_addr/o_rd_data                       : register-file write port
// Modports: slave = the controller, master = requesters plus register file.
// ---------------------------------------------------------------------------
interface regfile_wb_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_alu_valid;
  logic              o_alu_ready;
  logic [ADDR_W-1:0] i_alu_rd_addr;
  logic [DATA_W-1:0] i_alu_rd_data;
  logic              i_lsu_valid;
  logic              o_lsu_ready;
  logic [ADDR_W-1:0] i_lsu_rd_addr;
  logic [DATA_W-1:0] i_lsu_rd_data;
  logic              o_rd_wren;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] o_rd_data;

  modport slave (
    input  i_alu_valid, i_alu_rd_addr, i_alu_rd_data,
    input  i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
    output o_alu_ready, o_lsu_ready,
    output o_rd_wren, o_rd_addr, o_rd_data
  );

  modport master (
    output i_alu_valid, i_alu_rd_addr, i_alu_rd_data,
    output i_lsu_valid, i_lsu_rd_addr, i_lsu_rd_data,
    input  o_alu_ready, o_lsu_ready,
    input  o_rd_wren, o_rd_addr, o_rd_data
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
// Shares the single register-file write port between the ALU and the LSU
// with round-robin arbitration, registers the granted write (latency 1),
// and keeps a busy-bit scoreboard used to stall issue on RAW/WAW hazards.
// Ports:
//   i_clk, i_rst         : clock, synchronous active-high reset
//   wb (slave)           : ALU/LSU writeback channels and register-file write port
//   i_issue_*            : instruction presented for issue (valid, rd_wr, rd, rs1, rs2)
//   o_issue_stall        : hazard, issue must hold
//   o_busy_mask          : scoreboard, bit n = write to xn pending
//   o_err_wb             : sticky, writeback to a register that was not busy
// ---------------------------------------------------------------------------
module regfile_wb_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  regfile_wb_ctrl_if.slave       wb,
  input  logic                   i_issue_valid,
  input  logic                   i_issue_rd_wr,
  input  logic [ADDR_W-1:0]      i_issue_rd_addr,
  input  logic [ADDR_W-1:0]      i_issue_rs1_addr,
  input  logic [ADDR_W-1:0]      i_issue_rs2_addr,
  output logic                   o_issue_stall,
  output logic [(2**ADDR_W)-1:0] o_busy_mask,
  output logic                   o_err_wb
);
  localparam int NREG = 2**ADDR_W;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              rd_wren_q, rd_wren_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              err_q, err_d;

  logic              grant_alu, grant_lsu, hs;
  logic [ADDR_W-1:0] hs_addr;
  logic [DATA_W-1:0] hs_data;
  logic              issue_fire;

  // Arbitration: a lone requester always wins; on a tie the requester that
  // did not win last time is granted, bounding any wait to one cycle.
  always_comb begin
    grant_alu    = wb.i_alu_valid && (!wb.i_lsu_valid || last_grant_q == GNT_LSU);
    grant_lsu    = wb.i_lsu_valid && !grant_alu;
    hs           = grant_alu || grant_lsu;
    hs_addr      = grant_alu ? wb.i_alu_rd_addr : wb.i_lsu_rd_addr;
    hs_data      = grant_alu ? wb.i_alu_rd_data : wb.i_lsu_rd_data;
    last_grant_d = last_grant_q;
    if (grant_alu) begin
      last_grant_d = GNT_ALU;
    end else if (grant_lsu) begin
      last_grant_d = GNT_LSU;
    end
  end

  assign wb.o_alu_ready = grant_alu;
  assign wb.o_lsu_ready = grant_lsu;

  // Write stage: writes to x0 are accepted but never reach the register file.
  always_comb begin
    rd_wren_d = hs && (hs_addr != '0);
    rd_addr_d = hs ? hs_addr : rd_addr_q;
    rd_data_d = hs ? hs_data : rd_data_q;
    err_d     = err_q || (hs && (hs_addr != '0) && !busy_q[hs_addr]);
  end

  // busy_q[0] is never set, so x0 operands can never stall.
  assign o_issue_stall = i_issue_valid &&
                         (busy_q[i_issue_rs1_addr] || busy_q[i_issue_rs2_addr] ||
                          (i_issue_rd_wr && busy_q[i_issue_rd_addr]));
  assign issue_fire    = i_issue_valid && !o_issue_stall;

  // Scoreboard: a bit clears when its write is on the port; a new issue to
  // the same register in that cycle keeps it set.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy_d[gi] = 1'b0;
      end else begin : g_xn
        logic set_b, clr_b;
        assign set_b      = issue_fire && i_issue_rd_wr && (i_issue_rd_addr == ADDR_W'(gi));
        assign clr_b      = rd_wren_q && (rd_addr_q == ADDR_W'(gi));
        assign busy_d[gi] = set_b || (busy_q[gi] && !clr_b);
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_grant_q <= GNT_LSU;
      rd_wren_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      busy_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_wren_q    <= rd_wren_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign wb.o_rd_wren = rd_wren_q;
  assign wb.o_rd_addr = rd_addr_q;
  assign wb.o_rd_data = rd_data_q;
  assign o_busy_mask  = busy_q;
  assign o_err_wb     = err_q;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_issue_valid, i_issue_rd_wr;
  logic [AW-1:0] i_issue_rd_addr, i_issue_rs1_addr, i_issue_rs2_addr;
  logic          o_issue_stall;
  logic [NR-1:0] o_busy_mask;
  logic          o_err_wb;

  regfile_wb_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  regfile_wb_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .wb               (bus),
    .i_issue_valid    (i_issue_valid),
    .i_issue_rd_wr    (i_issue_rd_wr),
    .i_issue_rd_addr  (i_issue_rd_addr),
    .i_issue_rs1_addr (i_issue_rs1_addr),
    .i_issue_rs2_addr (i_issue_rs2_addr),
    .o_issue_stall    (o_issue_stall),
    .o_busy_mask      (o_busy_mask),
    .o_err_wb         (o_err_wb)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit av; logic [4:0] aa; logic [31:0] ad;
    bit lv; logic [4:0] la; logic [31:0] ld;
    bit iv; bit iw; logic [4:0] ird, irs1, irs2;
    bit e_ar, e_lr, e_st, e_wr; logic [4:0] e_addr; logic [31:0] e_data;
    logic [31:0] e_busy; bit e_err;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(
    input bit av, input logic [4:0] aa, input logic [31:0] ad,
    input bit lv, input logic [4:0] la, input logic [31:0] ld,
    input bit iv, input bit iw, input logic [4:0] ird, input logic [4:0] irs1, input logic [4:0] irs2,
    input bit ear, input bit elr, input bit est, input bit ewr,
    input logic [4:0] eaddr, input logic [31:0] edata, input logic [31:0] ebusy, input bit eerr);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.lv = lv; v.la = la; v.ld = ld;
    v.iv = iv; v.iw = iw; v.ird = ird; v.irs1 = irs1; v.irs2 = irs2;
    v.e_ar = ear; v.e_lr = elr; v.e_st = est; v.e_wr = ewr;
    v.e_addr = eaddr; v.e_data = edata; v.e_busy = ebusy; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit lv, input logic [4:0] la, input logic [31:0] ld,
                       input bit iv, input bit iw, input logic [4:0] ird,
                       input logic [4:0] irs1, input logic [4:0] irs2);
    bus.i_alu_valid = av; bus.i_alu_rd_addr = aa; bus.i_alu_rd_data = ad;
    bus.i_lsu_valid = lv; bus.i_lsu_rd_addr = la; bus.i_lsu_rd_data = ld;
    i_issue_valid = iv; i_issue_rd_wr = iw; i_issue_rd_addr = ird;
    i_issue_rs1_addr = irs1; i_issue_rs2_addr = irs2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Ends positioned 1 time unit after the edge that applied the reset.
  task automatic do_reset();
    i_rst = 1'b1;
    idle();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  // Reference model state (random phase)
  bit          m_busy[NR];
  bit          m_pv;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;
  bit          m_err;
  bit          m_last_lsu;

  function automatic logic [4:0] pick_wb();
    int q[$];
    for (int r = 1; r < NR; r++) if (m_busy[r]) q.push_back(r);
    if (q.size() > 0 && $urandom_range(0, 3) != 0) return 5'(q[$urandom_range(0, q.size() - 1)]);
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    // Cycle-by-cycle directed table, applied from reset.
    vecs[0]  = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,0,0, 0,0,            32'h0,   0);
    vecs[1]  = mk(0,0,0,            0,0,0,            1,1,5,1,2, 0,0,0,0, 0,0,            32'h0,   0);
    vecs[2]  = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,0,0, 0,0,            32'h20,  0);
    vecs[3]  = mk(1,5,32'hDEADBEEF, 0,0,0,            0,0,0,0,0, 1,0,0,0, 0,0,            32'h20,  0);
    vecs[4]  = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,0,1, 5,32'hDEADBEEF, 32'h20,  0);
    vecs[5]  = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,0,0, 0,0,            32'h0,   0);
    vecs[6]  = mk(0,0,0,            0,0,0,            1,1,7,0,0, 0,0,0,0, 0,0,            32'h0,   0);
    vecs[7]  = mk(0,0,0,            0,0,0,            1,1,9,0,0, 0,0,0,0, 0,0,            32'h80,  0);
    vecs[8]  = mk(0,0,0,            0,0,0,            1,1,10,0,0,0,0,0,0, 0,0,            32'h280, 0);
    vecs[9]  = mk(1,7,32'hA7,       1,9,32'hB9,       0,0,0,0,0, 0,1,0,0, 0,0,            32'h680, 0);
    vecs[10] = mk(1,7,32'hA7,       1,10,32'hC10,     0,0,0,0,0, 1,0,0,1, 9,32'hB9,       32'h680, 0);
    vecs[11] = mk(1,0,32'h1234,     1,10,32'hC10,     0,0,0,0,0, 0,1,0,1, 7,32'hA7,       32'h480, 0);
    vecs[12] = mk(1,0,32'h1234,     0,0,0,            0,0,0,0,0, 1,0,0,1, 10,32'hC10,     32'h400, 0);
    vecs[13] = mk(0,0,0,            0,0,0,            1,1,0,0,0, 0,0,0,0, 0,0,            32'h0,   0);
    vecs[14] = mk(0,0,0,            0,0,0,            1,1,3,0,0, 0,0,0,0, 0,0,            32'h0,   0);
    vecs[15] = mk(0,0,0,            0,0,0,            1,1,4,1,3, 0,0,1,0, 0,0,            32'h8,   0);
    vecs[16] = mk(1,3,32'h33,       0,0,0,            1,1,4,1,3, 1,0,1,0, 0,0,            32'h8,   0);
    vecs[17] = mk(0,0,0,            0,0,0,            1,1,4,1,3, 0,0,1,1, 3,32'h33,       32'h8,   0);
    vecs[18] = mk(0,0,0,            0,0,0,            1,1,4,1,3, 0,0,0,0, 0,0,            32'h0,   0);
    vecs[19] = mk(0,0,0,            0,0,0,            1,1,4,0,0, 0,0,1,0, 0,0,            32'h10,  0);
    vecs[20] = mk(0,0,0,            1,4,32'h44,       1,1,4,0,0, 0,1,1,0, 0,0,            32'h10,  0);
    vecs[21] = mk(0,0,0,            0,0,0,            1,1,4,0,0, 0,0,1,1, 4,32'h44,       32'h10,  0);
    vecs[22] = mk(0,0,0,            0,0,0,            1,1,4,0,0, 0,0,0,0, 0,0,            32'h0,   0);
    vecs[23] = mk(0,0,0,            1,12,32'h12C,     0,0,0,0,0, 0,1,0,0, 0,0,            32'h10,  0);
    vecs[24] = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,0,1, 12,32'h12C,     32'h10,  1);
    vecs[25] = mk(0,0,0,            0,0,0,            0,0,0,0,0, 0,0,0,0, 0,0,            32'h10,  1);

    do_reset();
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].lv, vecs[i].la, vecs[i].ld,
            vecs[i].iv, vecs[i].iw, vecs[i].ird, vecs[i].irs1, vecs[i].irs2);
      @(negedge i_clk);
      $display("vec %0d: ar=%0b lr=%0b stall=%0b wren=%0b addr=%0d data=0x%0h busy=0x%0h err=%0b",
               i, bus.o_alu_ready, bus.o_lsu_ready, o_issue_stall, bus.o_rd_wren,
               bus.o_rd_addr, bus.o_rd_data, o_busy_mask, o_err_wb);
      chk($sformatf("v%0d.alu_ready", i), 32'(bus.o_alu_ready), 32'(vecs[i].e_ar));
      chk($sformatf("v%0d.lsu_ready", i), 32'(bus.o_lsu_ready), 32'(vecs[i].e_lr));
      chk($sformatf("v%0d.stall", i),     32'(o_issue_stall),   32'(vecs[i].e_st));
      chk($sformatf("v%0d.wren", i),      32'(bus.o_rd_wren),   32'(vecs[i].e_wr));
      if (vecs[i].e_wr) begin
        chk($sformatf("v%0d.addr", i), 32'(bus.o_rd_addr), 32'(vecs[i].e_addr));
        chk($sformatf("v%0d.data", i), bus.o_rd_data, vecs[i].e_data);
      end
      chk($sformatf("v%0d.busy", i), o_busy_mask, vecs[i].e_busy);
      chk($sformatf("v%0d.err", i),  32'(o_err_wb), 32'(vecs[i].e_err));
      @(posedge i_clk); #1;
    end

    // One-cycle reset clears the sticky error and the scoreboard.
    i_rst = 1'b1; idle();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    $display("reset: wren=%0b busy=0x%0h err=%0b", bus.o_rd_wren, o_busy_mask, o_err_wb);
    chk("rst.err", 32'(o_err_wb), 32'd0);
    chk("rst.busy", o_busy_mask, 32'h0);
    chk("rst.wren", 32'(bus.o_rd_wren), 32'd0);
    @(posedge i_clk); #1;

    // Reset in the cycle after a handshake drops the pending write.
    drive(0, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0);
    @(posedge i_clk); #1;
    drive(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge i_clk);
    chk("rstwb.ready", 32'(bus.o_alu_ready), 32'd1);
    chk("rstwb.busy", o_busy_mask, 32'h40);
    @(posedge i_clk); #1;
    i_rst = 1'b1; idle();
    @(negedge i_clk);
    chk("rstwb.wren_before", 32'(bus.o_rd_wren), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    $display("reset after handshake: wren=%0b busy=0x%0h", bus.o_rd_wren, o_busy_mask);
    chk("rstwb.wren_after", 32'(bus.o_rd_wren), 32'd0);
    chk("rstwb.busy_after", o_busy_mask, 32'h0);
    @(posedge i_clk); #1;

    // Randomized phase against the reference model.
    begin
      bit a_v = 0, l_v = 0, iv = 0, iw = 0, rst_r;
      logic [4:0] a_a = 0, l_a = 0, ird = 0, rs1 = 0, rs2 = 0;
      logic [31:0] a_d = 0, l_d = 0;
      bit a_gnt = 0, l_gnt = 0, st_prev = 0;
      do_reset();
      for (int r = 0; r < NR; r++) m_busy[r] = 0;
      m_pv = 0; m_pa = 0; m_pd = 0; m_err = 0; m_last_lsu = 1;
      for (int c = 0; c < 800; c++) begin
        bit e_ar, e_lr, e_st, fire, hs;
        logic [4:0] h_a;
        logic [31:0] h_d, e_busy;
        bit busy_old[NR];
        if (!a_v || a_gnt) begin
          a_v = ($urandom_range(0, 9) < 5); a_a = pick_wb(); a_d = $urandom;
        end
        if (!l_v || l_gnt) begin
          l_v = ($urandom_range(0, 9) < 5); l_a = pick_wb(); l_d = $urandom;
        end
        if (!(iv && st_prev)) begin
          iv = ($urandom_range(0, 9) < 6); iw = ($urandom_range(0, 3) != 0);
          ird = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
        end
        rst_r = ($urandom_range(0, 99) == 0);
        i_rst = rst_r;
        drive(a_v, a_a, a_d, l_v, l_a, l_d, iv, iw, ird, rs1, rs2);
        @(negedge i_clk);
        e_ar = a_v && (!l_v || m_last_lsu);
        e_lr = l_v && !e_ar;
        e_st = iv && (m_busy[rs1] || m_busy[rs2] || (iw && m_busy[ird]));
        e_busy = 0;
        for (int r = 0; r < NR; r++) e_busy[r] = m_busy[r];
        chk($sformatf("r%0d.alu_ready", c), 32'(bus.o_alu_ready), 32'(e_ar));
        chk($sformatf("r%0d.lsu_ready", c), 32'(bus.o_lsu_ready), 32'(e_lr));
        chk($sformatf("r%0d.stall", c), 32'(o_issue_stall), 32'(e_st));
        chk($sformatf("r%0d.wren", c), 32'(bus.o_rd_wren), 32'(m_pv));
        if (m_pv) begin
          chk($sformatf("r%0d.addr", c), 32'(bus.o_rd_addr), 32'(m_pa));
          chk($sformatf("r%0d.data", c), bus.o_rd_data, m_pd);
        end
        chk($sformatf("r%0d.busy", c), o_busy_mask, e_busy);
        chk($sformatf("r%0d.err", c), 32'(o_err_wb), 32'(m_err));
        hs = e_ar || e_lr;
        h_a = e_ar ? a_a : l_a;
        h_d = e_ar ? a_d : l_d;
        if (hs) $display("rand %0d: %s wb x%0d=0x%0h%s", c, e_ar ? "alu" : "lsu", h_a, h_d, rst_r ? " (reset)" : "");
        fire = iv && !e_st;
        if (rst_r) begin
          for (int r = 0; r < NR; r++) m_busy[r] = 0;
          m_pv = 0; m_err = 0; m_last_lsu = 1;
        end else begin
          busy_old = m_busy;
          if (m_pv) m_busy[m_pa] = 0;
          if (fire && iw && ird != 0) m_busy[ird] = 1;
          if (hs && h_a != 0 && !busy_old[h_a]) m_err = 1;
          if (hs) m_last_lsu = e_lr;
          m_pv = hs && (h_a != 0);
          if (hs) begin m_pa = h_a; m_pd = h_d; end
        end
        a_gnt = e_ar; l_gnt = e_lr; st_prev = e_st;
        @(posedge i_clk); #1;
      end
      i_rst = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
